// File: rtl/polilobinho_pkg.sv
// rtl/polilobinho_pkg.sv - shared game FSM state codes, LED colours and LED display modes
//
// Purpose: common definitions for the game-status RGB LED path.
//   - State codes INICIAL..LOBO_GANHOU as driven on the game FSM db_estado bus.
//   - Colour constants, bit order {R,G,B}.
//   - 2-bit LED display mode encoding (also the modo_q FSM state encoding).
//   - mapa_estado(): state code -> {colour, entry mode}.
// Ports: none (package).
package polilobinho_pkg;

   localparam logic [4:0] INICIAL            = 5'd0;
   localparam logic [4:0] PREPARA            = 5'd1;
   localparam logic [4:0] ESPERA_JOGADORES   = 5'd2;
   localparam logic [4:0] SORTEIA_PAPEIS     = 5'd3;
   localparam logic [4:0] MOSTRA_PAPEL       = 5'd4;
   localparam logic [4:0] NOITE              = 5'd5;
   localparam logic [4:0] LOBO_ESCOLHE       = 5'd6;
   localparam logic [4:0] ESPERA_LOBO        = 5'd7;
   localparam logic [4:0] MEDICO_ESCOLHE     = 5'd8;
   localparam logic [4:0] ESPERA_MEDICO      = 5'd9;
   localparam logic [4:0] RESOLVE_NOITE      = 5'd10;
   localparam logic [4:0] ANUNCIAR_MORTE     = 5'd11;
   localparam logic [4:0] VERIFICA_FIM_NOITE = 5'd12;
   localparam logic [4:0] DIA                = 5'd13;
   localparam logic [4:0] DISCUSSAO          = 5'd14;
   localparam logic [4:0] VOTACAO            = 5'd15;
   localparam logic [4:0] PROCESSA_VOTO      = 5'd16;
   localparam logic [4:0] VERIFICA_FIM_DIA   = 5'd17;
   localparam logic [4:0] ELIMINA            = 5'd18;
   localparam logic [4:0] ANUNCIA_ELIMINADO  = 5'd19;
   localparam logic [4:0] LOBO_PERDEU        = 5'd20;
   localparam logic [4:0] LOBO_GANHOU        = 5'd21;

   localparam logic [2:0] COR_OFF    = 3'b000;
   localparam logic [2:0] COR_RED    = 3'b100;
   localparam logic [2:0] COR_GREEN  = 3'b010;
   localparam logic [2:0] COR_BLUE   = 3'b001;
   localparam logic [2:0] COR_PURPLE = 3'b101;
   localparam logic [2:0] COR_YELLOW = 3'b110;
   localparam logic [2:0] COR_CYAN   = 3'b011;
   localparam logic [2:0] COR_WHITE  = 3'b111;

   localparam logic [1:0] MODO_OFF       = 2'd0;
   localparam logic [1:0] MODO_STEADY    = 2'd1;
   localparam logic [1:0] MODO_BLINK_ON  = 2'd2;
   localparam logic [1:0] MODO_BLINK_OFF = 2'd3;

   typedef struct packed {
      logic [2:0] cor;
      logic [1:0] modo;
   } mapa_t;

   // Codes above the 5-bit range are unused by the game FSM and show dark.
   function automatic mapa_t mapa_estado(input logic [31:0] codigo);
      mapa_t m;
      m.cor  = COR_OFF;
      m.modo = MODO_OFF;
      if (codigo[31:5] == 27'd0) begin
         case (codigo[4:0])
            NOITE, LOBO_ESCOLHE, ESPERA_LOBO, MEDICO_ESCOLHE,
            ESPERA_MEDICO, RESOLVE_NOITE, ELIMINA: begin
               m.cor  = COR_PURPLE;
               m.modo = MODO_STEADY;
            end
            ANUNCIAR_MORTE: begin
               m.cor  = COR_RED;
               m.modo = MODO_STEADY;
            end
            DIA, DISCUSSAO, ANUNCIA_ELIMINADO: begin
               m.cor  = COR_CYAN;
               m.modo = MODO_STEADY;
            end
            VOTACAO: begin
               m.cor  = COR_BLUE;
               m.modo = MODO_STEADY;
            end
            PROCESSA_VOTO: begin
               m.cor  = COR_BLUE;
               m.modo = MODO_BLINK_ON;
            end
            LOBO_PERDEU: begin
               m.cor  = COR_GREEN;
               m.modo = MODO_BLINK_ON;
            end
            LOBO_GANHOU: begin
               m.cor  = COR_RED;
               m.modo = MODO_BLINK_ON;
            end
            INICIAL, PREPARA, ESPERA_JOGADORES, SORTEIA_PAPEIS,
            MOSTRA_PAPEL, VERIFICA_FIM_NOITE, VERIFICA_FIM_DIA: begin
               m.cor  = COR_OFF;
               m.modo = MODO_OFF;
            end
            default: begin
               m.cor  = COR_OFF;
               m.modo = MODO_OFF;
            end
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/rgb_pwm.sv
// rtl/rgb_pwm.sv - free-running PWM counter and brightness comparator for the RGB LED
//
// Purpose: shared brightness gate for all three LED channels.
// Ports:
//   clock    in  1      system clock, rising edge
//   reset_n  in  1      asynchronous active-low reset
//   brilho   in  PWM_W  brightness; 0 = dark, all-ones = always on
//   pwm_on   out 1      channel enable for the current PWM slot
module rgb_pwm #(
   parameter int PWM_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [PWM_W-1:0] brilho,
   output logic             pwm_on
);

   logic [PWM_W-1:0] pwm_cnt_q;
   logic [PWM_W-1:0] pwm_cnt_d;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   // The counter never reaches 2^PWM_W, so all-ones brightness needs the
   // explicit override to be continuously on.
   assign pwm_on = (pwm_cnt_q < brilho) || (&brilho);

endmodule

// File: rtl/rgb_estado_driver.sv
// rtl/rgb_estado_driver.sv - game FSM state to dimmable, blinking RGB LED driver
//
// Purpose: registers db_estado, maps it to a base colour and display mode
// (off / steady / blink) and drives the PWM-gated LED channels.
// Optional feature: define RGB_FLASH_EN to show a white flash of FLASH_CYCLES
// cycles on every state change (blink counter held during the flash).
// Ports:
//   clock         in  1         system clock, rising edge
//   reset_n       in  1         asynchronous active-low reset
//   db_estado     in  ESTADO_W  game FSM state code
//   brilho        in  PWM_W     LED brightness
//   RGB_estado    out 3         PWM-modulated LED drive {R,G,B}, registered
//   cor_base      out 3         unmodulated colour of the current state
//   mudou_estado  out 1         one-cycle pulse on a registered state change
module rgb_estado_driver
   import polilobinho_pkg::*;
#(
   parameter int ESTADO_W     = 5,
   parameter int PWM_W        = 8,
   parameter int BLINK_DIV    = 25_000_000,
   parameter int FLASH_CYCLES = 5_000_000
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [ESTADO_W-1:0] db_estado,
   input  logic [PWM_W-1:0]    brilho,
   output logic [2:0]          RGB_estado,
   output logic [2:0]          cor_base,
   output logic                mudou_estado
);

   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam logic [BLINK_W-1:0] BLINK_ULT = BLINK_W'(BLINK_DIV - 1);

   logic [ESTADO_W-1:0] estado_q, estado_d;
   logic [ESTADO_W-1:0] estado_ant_q, estado_ant_d;
   logic                mudou_q, mudou_d;
   logic [2:0]          cor_base_q, cor_base_d;
   logic [1:0]          modo_q, modo_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic                blink_fase_q, blink_fase_d;
   logic [2:0]          rgb_q, rgb_d;

   logic                pwm_on;
   logic                blink_wrap;
   logic                flash_ativo;
   logic [2:0]          cor_vis;
   mapa_t               mapa;

   rgb_pwm #(
      .PWM_W (PWM_W)
   ) u_pwm (
      .clock   (clock),
      .reset_n (reset_n),
      .brilho  (brilho),
      .pwm_on  (pwm_on)
   );

`ifdef RGB_FLASH_EN
   localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);
   localparam logic [FLASH_W-1:0] FLASH_CARGA = FLASH_W'(FLASH_CYCLES);

   logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;

   always_comb begin
      flash_cnt_d = flash_cnt_q;
      if (mudou_d) begin
         flash_cnt_d = FLASH_CARGA;
      end else if (flash_cnt_q != '0) begin
         flash_cnt_d = flash_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         flash_cnt_q <= '0;
      end else begin
         flash_cnt_q <= flash_cnt_d;
      end
   end

   assign flash_ativo = (flash_cnt_q != '0);
`else
   assign flash_ativo = 1'b0;
`endif

   // mudou_d is the combinational change detect; every state-change side
   // effect (colour, mode, blink restart, flash load) is taken on the same
   // edge that raises mudou_estado, so RGB_estado follows one cycle later.
   always_comb begin
      estado_d     = db_estado;
      estado_ant_d = estado_q;
      mudou_d      = (estado_q != estado_ant_q);
      mapa         = mapa_estado(32'(estado_q));
      cor_base_d   = mapa.cor;
      blink_wrap   = (blink_cnt_q == BLINK_ULT);

      // A change on the same cycle as a wrap wins: restart lit from zero.
      blink_cnt_d  = blink_cnt_q;
      blink_fase_d = blink_fase_q;
      if (mudou_d) begin
         blink_cnt_d  = '0;
         blink_fase_d = 1'b1;
      end else if (!flash_ativo) begin
         if (blink_wrap) begin
            blink_cnt_d  = '0;
            blink_fase_d = ~blink_fase_q;
         end else begin
            blink_cnt_d  = blink_cnt_q + 1'b1;
         end
      end

      modo_d = modo_q;
      if (mudou_d) begin
         modo_d = mapa.modo;
      end else if (!flash_ativo && blink_wrap) begin
         case (modo_q)
            MODO_BLINK_ON:  modo_d = MODO_BLINK_OFF;
            MODO_BLINK_OFF: modo_d = MODO_BLINK_ON;
            default:        modo_d = modo_q;
         endcase
      end

      case (modo_q)
         MODO_STEADY:    cor_vis = cor_base_q;
         MODO_BLINK_ON,
         MODO_BLINK_OFF: cor_vis = cor_base_q & {3{blink_fase_q}};
         default:        cor_vis = COR_OFF;
      endcase
      if (flash_ativo) begin
         cor_vis = COR_WHITE;
      end

      rgb_d = cor_vis & {3{pwm_on}};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q     <= '0;
         estado_ant_q <= '0;
         mudou_q      <= 1'b0;
         cor_base_q   <= COR_OFF;
         modo_q       <= MODO_OFF;
         blink_cnt_q  <= '0;
         blink_fase_q <= 1'b1;
         rgb_q        <= COR_OFF;
      end else begin
         estado_q     <= estado_d;
         estado_ant_q <= estado_ant_d;
         mudou_q      <= mudou_d;
         cor_base_q   <= cor_base_d;
         modo_q       <= modo_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_fase_q <= blink_fase_d;
         rgb_q        <= rgb_d;
      end
   end

   assign RGB_estado   = rgb_q;
   assign cor_base     = cor_base_q;
   assign mudou_estado = mudou_q;

endmodule

// File: tb/tb_rgb_estado_driver.sv
// tb/tb_rgb_estado_driver.sv - directed self-checking bench for rgb_estado_driver
module tb_rgb_estado_driver;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [4:0] db_estado;
   logic [3:0] brilho;
   logic [2:0] RGB_estado;
   logic [2:0] cor_base;
   logic       mudou_estado;

   int n_assert = 0;
   int n_fail   = 0;

   rgb_estado_driver #(
      .ESTADO_W     (5),
      .PWM_W        (4),
      .BLINK_DIV    (8),
      .FLASH_CYCLES (3)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .db_estado    (db_estado),
      .brilho       (brilho),
      .RGB_estado   (RGB_estado),
      .cor_base     (cor_base),
      .mudou_estado (mudou_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d (%b) expected %0d (%b)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [2:0] exp_cor(input int c);
      case (c)
         5, 6, 7, 8, 9, 10, 18: return 3'b101;
         11:                    return 3'b100;
         13, 14, 19:            return 3'b011;
         15, 16:                return 3'b001;
         20:                    return 3'b010;
         21:                    return 3'b100;
         default:               return 3'b000;
      endcase
   endfunction

   initial begin
      int on_cnt;
      int bad_cnt;

      // Reset held with state 7.
      reset_n   = 1'b0;
      db_estado = 5'd7;
      brilho    = 4'd15;
      step(3);
      check("rst_rgb",   {5'd0, RGB_estado}, 8'd0);
      check("rst_cor",   {5'd0, cor_base},   8'd0);
      check("rst_mudou", {7'd0, mudou_estado}, 8'd0);
      reset_n = 1'b1;
      step(1);
      check("rel_k1_mudou", {7'd0, mudou_estado}, 8'd0);
      step(1);
      check("rel_k2_mudou", {7'd0, mudou_estado}, 8'd1);
      check("rel_k2_cor",   {5'd0, cor_base},   8'b101);
      step(1);
      check("rel_k3_mudou", {7'd0, mudou_estado}, 8'd0);
`ifndef RGB_FLASH_EN
      check("rel_k3_rgb",   {5'd0, RGB_estado}, 8'b101);
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("steady_purple", {5'd0, RGB_estado}, 8'b101);
      end

      // Brightness 4 of 16 on cyan.
      db_estado = 5'd13;
      brilho    = 4'd4;
      step(4);
      for (int w = 0; w < 2; w++) begin
         on_cnt  = 0;
         bad_cnt = 0;
         for (int i = 0; i < 16; i++) begin
            if (RGB_estado == 3'b011) on_cnt++;
            else if (RGB_estado != 3'b000) bad_cnt++;
            step(1);
         end
         check("pwm4_on_count",  8'(on_cnt),  8'd4);
         check("pwm4_bad_count", 8'(bad_cnt), 8'd0);
      end

      // Red blink, 8 lit / 8 dark.
      db_estado = 5'd21;
      brilho    = 4'd15;
      step(3);
      for (int i = 0; i < 8; i++) begin
         check("blink_lit1", {5'd0, RGB_estado}, 8'b100);
         step(1);
      end
      for (int i = 0; i < 8; i++) begin
         check("blink_dark", {5'd0, RGB_estado}, 8'b000);
         step(1);
      end
      for (int i = 0; i < 8; i++) begin
         check("blink_lit2", {5'd0, RGB_estado}, 8'b100);
         step(1);
      end
      step(1);
      check("blink_dark2", {5'd0, RGB_estado}, 8'b000);
      // Switch to green blink while dark.
      db_estado = 5'd20;
      step(1);
      check("sw20_k1_rgb", {5'd0, RGB_estado}, 8'b000);
      step(1);
      check("sw20_k2_mudou", {7'd0, mudou_estado}, 8'd1);
      check("sw20_k2_cor",   {5'd0, cor_base},   8'b010);
      for (int i = 0; i < 8; i++) begin
         step(1);
         check("sw20_lit", {5'd0, RGB_estado}, 8'b010);
      end
      step(1);
      check("sw20_dark", {5'd0, RGB_estado}, 8'b000);
`endif

      // Sweep all codes.
      db_estado = 5'd31;
      brilho    = 4'd15;
      step(4);
      for (int c = 0; c < 32; c++) begin
         db_estado = 5'(c);
         step(2);
         check($sformatf("sweep_cor_%0d", c), {5'd0, cor_base}, {5'd0, exp_cor(c)});
         check($sformatf("sweep_mudou_%0d", c), {7'd0, mudou_estado}, 8'd1);
      end

      // One-cycle glitch gives two pulses.
      db_estado = 5'd15;
      step(4);
      db_estado = 5'd16;
      step(1);
      db_estado = 5'd15;
      step(1);
      check("glitch_p1", {7'd0, mudou_estado}, 8'd1);
      step(1);
      check("glitch_p2", {7'd0, mudou_estado}, 8'd1);
      step(1);
      check("glitch_end", {7'd0, mudou_estado}, 8'd0);
      check("glitch_cor", {5'd0, cor_base}, 8'b001);

      // Asynchronous reset mid-blink.
      db_estado = 5'd16;
      step(5);
`ifndef RGB_FLASH_EN
      check("pre_arst_rgb", {5'd0, RGB_estado}, 8'b001);
`endif
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_rgb",   {5'd0, RGB_estado}, 8'd0);
      check("arst_cor",   {5'd0, cor_base},   8'd0);
      check("arst_mudou", {7'd0, mudou_estado}, 8'd0);
      db_estado = 5'd0;
      step(2);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("post_rst_no_pulse", {7'd0, mudou_estado}, 8'd0);
         check("post_rst_cor",      {5'd0, cor_base},     8'd0);
      end

`ifdef RGB_FLASH_EN
      db_estado = 5'd5;
      step(12);
      db_estado = 5'd13;
      step(3);
      check("flash1_w1", {5'd0, RGB_estado}, 8'b111);
      step(1);
      check("flash1_w2", {5'd0, RGB_estado}, 8'b111);
      step(1);
      check("flash1_w3", {5'd0, RGB_estado}, 8'b111);
      step(1);
      check("flash1_cyan", {5'd0, RGB_estado}, 8'b011);

      db_estado = 5'd5;
      step(12);
      db_estado = 5'd13;
      step(3);
      check("flash2_w1", {5'd0, RGB_estado}, 8'b111);
      db_estado = 5'd15;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("flash2_white", {5'd0, RGB_estado}, 8'b111);
      end
      step(1);
      check("flash2_blue", {5'd0, RGB_estado}, 8'b001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
